// File: rtl/mm_col_sequencer_pkg.sv
// Shared types and board constants for the motor-matrix column sequencer.
package mm_col_sequencer_pkg;

    localparam int unsigned MOTOR_COLS = 8;

    typedef enum logic [2:0] {
        IDLE,
        DEAD,
        DRIVE,
        UPDATE,
        FINALIZE
    } mm_seq_state_t;

endpackage

// File: rtl/mm_next_col.sv
// Combinational priority finder: next set mask bit above col, and lowest set bit.
module mm_next_col
    import mm_col_sequencer_pkg::*;
#(
    parameter int unsigned NUM_COLS = MOTOR_COLS,
    parameter int unsigned COL_W    = $clog2(NUM_COLS)
) (
    input  logic [NUM_COLS-1:0] mask,
    input  logic [COL_W-1:0]    col,
    output logic [COL_W-1:0]    next_col,
    output logic                found,
    output logic [COL_W-1:0]    lowest_col,
    output logic                empty
);

    // Scan from the top down so the last hit is the lowest qualifying bit.
    always_comb begin
        next_col   = '0;
        found      = 1'b0;
        lowest_col = '0;
        empty      = (mask == '0);
        for (int i = int'(NUM_COLS) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest_col = COL_W'(i);
                if (i > int'(col)) begin
                    next_col = COL_W'(i);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mm_col_sequencer.sv
// Column-multiplex sequencer: one-hot drives masked columns with break-before-make
// dead time, repeats for a programmable number of passes, supports abort.
module mm_col_sequencer
    import mm_col_sequencer_pkg::*;
#(
    parameter int unsigned NUM_COLS = MOTOR_COLS,
    parameter int unsigned COL_W    = $clog2(NUM_COLS),
    parameter int unsigned PASS_W   = 8,
    parameter int unsigned DEAD_W   = 6
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [NUM_COLS-1:0] col_mask,
    input  logic [PASS_W-1:0]   num_passes,
    input  logic [DEAD_W-1:0]   dead_cycles,
    input  logic                col_done,
    input  logic                update_done,
    output logic [COL_W-1:0]    col,
    output logic [NUM_COLS-1:0] col_en,
    output logic                col_start,
    output logic                col_finished,
    output logic                update_req,
    output logic [PASS_W-1:0]   pass_count,
    output logic                busy,
    output logic                done,
    output logic                aborted
);

    localparam int unsigned PCMP_W = PASS_W + 1;

    mm_seq_state_t       state_q, state_d;
    logic [NUM_COLS-1:0] mask_q, mask_d;
    logic [PASS_W-1:0]   passes_q, passes_d;
    logic [DEAD_W-1:0]   dead_q, dead_d;
    logic [DEAD_W-1:0]   dead_cnt_q, dead_cnt_d;
    logic [COL_W-1:0]    col_d;
    logic [PASS_W-1:0]   pass_count_d;
    logic                aborted_d;
    logic [NUM_COLS-1:0] col_en_d;
    logic                col_start_d, col_finished_d, update_req_d, busy_d, done_d;

    logic [NUM_COLS-1:0] find_mask;
    logic [COL_W-1:0]    find_next, find_lowest;
    logic                find_found, find_empty;

    // In IDLE the finder looks at the incoming mask so the first column is known at start.
    assign find_mask = (state_q == IDLE) ? col_mask : mask_q;

    mm_next_col #(
        .NUM_COLS (NUM_COLS),
        .COL_W    (COL_W)
    ) u_next_col (
        .mask       (find_mask),
        .col        (col),
        .next_col   (find_next),
        .found      (find_found),
        .lowest_col (find_lowest),
        .empty      (find_empty)
    );

    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        passes_d       = passes_q;
        dead_d         = dead_q;
        dead_cnt_d     = dead_cnt_q;
        col_d          = col;
        pass_count_d   = pass_count;
        aborted_d      = aborted;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d       = col_mask;
                    passes_d     = num_passes;
                    dead_d       = dead_cycles;
                    dead_cnt_d   = dead_cycles;
                    col_d        = find_lowest;
                    pass_count_d = '0;
                    aborted_d    = 1'b0;
                    state_d      = (find_empty || num_passes == '0) ? FINALIZE : DEAD;
                end
            end
            DEAD: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = FINALIZE;
                end else if (dead_cnt_q == '0) begin
                    state_d = DRIVE;
                end else begin
                    dead_cnt_d = dead_cnt_q - DEAD_W'(1);
                end
            end
            DRIVE: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = FINALIZE;
                end else if (col_done) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = FINALIZE;
                end else if (update_done) begin
                    dead_cnt_d = dead_q;
                    if (find_found) begin
                        col_d   = find_next;
                        state_d = DEAD;
                    end else if ((PCMP_W'(pass_count) + PCMP_W'(1)) < PCMP_W'(passes_q)) begin
                        pass_count_d = pass_count + PASS_W'(1);
                        col_d        = find_lowest;
                        state_d      = DEAD;
                    end else begin
                        state_d = FINALIZE;
                    end
                end
            end
            FINALIZE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // Output images are derived from the next state so the registers line up with it.
        col_en_d       = (state_d == DRIVE || state_d == UPDATE) ? (NUM_COLS'(1) << col_d) : '0;
        col_start_d    = (state_q == DEAD) && (state_d == DRIVE);
        col_finished_d = (state_q == DRIVE) && (state_d == UPDATE);
        update_req_d   = (state_d == UPDATE);
        busy_d         = (state_d != IDLE);
        done_d         = (state_q == FINALIZE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            passes_q     <= '0;
            dead_q       <= '0;
            dead_cnt_q   <= '0;
            col          <= '0;
            pass_count   <= '0;
            aborted      <= 1'b0;
            col_en       <= '0;
            col_start    <= 1'b0;
            col_finished <= 1'b0;
            update_req   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            passes_q     <= passes_d;
            dead_q       <= dead_d;
            dead_cnt_q   <= dead_cnt_d;
            col          <= col_d;
            pass_count   <= pass_count_d;
            aborted      <= aborted_d;
            col_en       <= col_en_d;
            col_start    <= col_start_d;
            col_finished <= col_finished_d;
            update_req   <= update_req_d;
            busy         <= busy_d;
            done         <= done_d;
        end
    end

endmodule

// File: tb/tb_mm_col_sequencer.sv
// Self-checking bench for mm_col_sequencer: table scans, corner sequences, random scans.
module tb_mm_col_sequencer;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [7:0] col_mask;
    logic [7:0] num_passes;
    logic [5:0] dead_cycles;
    logic       col_done;
    logic       update_done;
    logic [2:0] col;
    logic [7:0] col_en;
    logic       col_start;
    logic       col_finished;
    logic       update_req;
    logic [7:0] pass_count;
    logic       busy;
    logic       done;
    logic       aborted;

    mm_col_sequencer #(
        .NUM_COLS (8),
        .PASS_W   (8),
        .DEAD_W   (6)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .col_mask     (col_mask),
        .num_passes   (num_passes),
        .dead_cycles  (dead_cycles),
        .col_done     (col_done),
        .update_done  (update_done),
        .col          (col),
        .col_en       (col_en),
        .col_start    (col_start),
        .col_finished (col_finished),
        .update_req   (update_req),
        .pass_count   (pass_count),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Driver-side model of the motor drivers, with random handshake latency.
    logic       resp_en;
    int         max_dly;
    logic       inj_en;
    logic [2:0] inj_col;

    initial begin
        int dc;
        int du;
        dc = 0;
        du = 0;
        col_done = 1'b0;
        update_done = 1'b0;
        abort = 1'b0;
        forever begin
            @(negedge clock);
            if (!resp_en || !reset_n) begin
                col_done = 1'b0;
                update_done = 1'b0;
                abort = 1'b0;
            end else begin
                if (col_en != '0 && !update_req) begin
                    if (dc == 0) begin
                        col_done = 1'b1;
                        abort = inj_en && (col == inj_col);
                    end else begin
                        dc--;
                    end
                end else begin
                    col_done = 1'b0;
                    abort = 1'b0;
                    dc = $urandom_range(0, max_dly);
                end
                if (update_req) begin
                    if (du == 0) update_done = 1'b1;
                    else du--;
                end else begin
                    update_done = 1'b0;
                    du = $urandom_range(0, max_dly);
                end
            end
        end
    end

    // Protocol monitor and observation log.
    int         obs_col[$];
    int         obs_pass[$];
    int         obs_dead[$];
    int         n_fin = 0;
    int         n_done = 0;
    int         n_hit = 0;
    int         dead_run = 0;
    logic [7:0] prev_en = '0;
    logic       hit;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) hit <= 1'b0;
        else          hit <= abort && col_done;
    end

    always @(negedge clock) begin
        if (reset_n) begin
            chk("onehot_or_zero", 32'($countones(col_en) <= 1), 32'(1));
            chk("break_before_make", 32'(prev_en == '0 || col_en == '0 || prev_en == col_en), 32'(1));
            if (col_start) begin
                obs_col.push_back(int'(col));
                obs_pass.push_back(int'(pass_count));
                obs_dead.push_back(dead_run);
                chk("col_en_at_start", 32'(col_en), 32'(8'd1 << col));
            end
            if (hit) begin
                n_hit++;
                chk("abort_col_en", 32'(col_en), 32'(0));
                chk("abort_no_finished", 32'(col_finished), 32'(0));
            end
            if (col_finished) n_fin++;
            if (done) n_done++;
            dead_run = (busy && col_en == '0) ? dead_run + 1 : 0;
            prev_en  = col_en;
        end else begin
            dead_run = 0;
            prev_en  = '0;
        end
    end

    task automatic start_scan(input logic [7:0] m, input logic [7:0] p, input logic [5:0] d, input int dly);
        @(negedge clock);
        max_dly     = dly;
        col_mask    = m;
        num_passes  = p;
        dead_cycles = d;
        start       = 1'b1;
        @(negedge clock);
        start       = 1'b0;
    endtask

    task automatic wait_done(input int bd);
        int t;
        t = 0;
        while (n_done == bd && t < 6000) begin
            @(negedge clock);
            #1;
            t++;
        end
        chk("done_seen", 32'(n_done > bd), 32'(1));
    endtask

    // Reference: every masked column in ascending order, repeated once per pass.
    task automatic check_scan(input logic [7:0] m, input logic [7:0] p, input logic [5:0] d,
                              input int bs, input int bf, input int bd);
        int ecol[$];
        int epass[$];
        int n;
        for (int pp = 0; pp < int'(p); pp++)
            for (int c = 0; c < 8; c++)
                if (m[c]) begin
                    ecol.push_back(c);
                    epass.push_back(pp);
                end
        n = obs_col.size() - bs;
        chk("start_count", 32'(n), 32'(ecol.size()));
        for (int i = 0; i < ecol.size() && i < n; i++) begin
            chk("seq_col", 32'(obs_col[bs+i]), 32'(ecol[i]));
            chk("seq_pass", 32'(obs_pass[bs+i]), 32'(epass[i]));
            chk("dead_len", 32'(obs_dead[bs+i]), 32'(int'(d) + 1));
        end
        chk("finished_count", 32'(n_fin - bf), 32'(ecol.size()));
        chk("done_count", 32'(n_done - bd), 32'(1));
        chk("aborted_clear", 32'(aborted), 32'(0));
        chk("final_col", 32'(col), 32'(ecol[$]));
        chk("final_pass", 32'(pass_count), 32'(int'(p) - 1));
    endtask

    task automatic run_scan(input logic [7:0] m, input logic [7:0] p, input logic [5:0] d, input int dly);
        int bs;
        int bf;
        int bd;
        bs = obs_col.size();
        bf = n_fin;
        bd = n_done;
        start_scan(m, p, d, dly);
        wait_done(bd);
        check_scan(m, p, d, bs, bf, bd);
    endtask

    task automatic empty_case(input logic [7:0] m, input logic [7:0] p);
        int         busy_n;
        int         done_at;
        logic [7:0] en_or;
        busy_n  = 0;
        done_at = -1;
        en_or   = '0;
        @(negedge clock);
        col_mask    = m;
        num_passes  = p;
        dead_cycles = 6'd3;
        start       = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            start = 1'b0;
            #1;
            if (busy) busy_n++;
            if (done && done_at < 0) done_at = i;
            en_or |= col_en;
        end
        chk("empty_busy_cycles", 32'(busy_n), 32'(1));
        chk("empty_done_latency", 32'(done_at), 32'(2));
        chk("empty_col_en", 32'(en_or), 32'(0));
        chk("empty_aborted", 32'(aborted), 32'(0));
    endtask

    typedef struct {
        logic [7:0] mask;
        logic [7:0] passes;
        logic [5:0] dead;
        int         dly;
        int         exp_starts;
        int         exp_first;
        int         exp_last;
        int         exp_pass;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int   bs;
        int   bf;
        int   bd;
        int   bh;
        logic found;

        vecs[0] = '{8'hA5, 8'd1,   6'd2, 2, 4,   0, 7, 0};
        vecs[1] = '{8'h81, 8'd3,   6'd1, 3, 6,   0, 7, 2};
        vecs[2] = '{8'h10, 8'd2,   6'd0, 1, 2,   4, 4, 1};
        vecs[3] = '{8'hFF, 8'd1,   6'd0, 0, 8,   0, 7, 0};
        vecs[4] = '{8'h01, 8'd255, 6'd0, 0, 255, 0, 0, 254};

        reset_n = 1'b0;
        start = 1'b0;
        col_mask = '0;
        num_passes = '0;
        dead_cycles = '0;
        resp_en = 1'b0;
        max_dly = 0;
        inj_en = 1'b0;
        inj_col = '0;

        repeat (3) @(negedge clock);
        #1;
        chk("rst_col", 32'(col), 32'(0));
        chk("rst_col_en", 32'(col_en), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_aborted", 32'(aborted), 32'(0));
        chk("rst_pass_count", 32'(pass_count), 32'(0));
        chk("rst_update_req", 32'(update_req), 32'(0));
        chk("rst_pulses", 32'({col_start, col_finished}), 32'(0));
        reset_n = 1'b1;
        resp_en = 1'b1;

        for (int v = 0; v < 5; v++) begin
            bs = obs_col.size();
            run_scan(vecs[v].mask, vecs[v].passes, vecs[v].dead, vecs[v].dly);
            chk("vec_starts", 32'(obs_col.size() - bs), 32'(vecs[v].exp_starts));
            if (obs_col.size() > bs) begin
                chk("vec_first_col", 32'(obs_col[bs]), 32'(vecs[v].exp_first));
                chk("vec_last_col", 32'(obs_col[$]), 32'(vecs[v].exp_last));
            end
            chk("vec_final_pass", 32'(pass_count), 32'(vecs[v].exp_pass));
        end

        empty_case(8'h00, 8'd1);
        empty_case(8'hFF, 8'd0);

        // Abort lands on the same edge as col_done for column 2.
        inj_col = 3'd2;
        inj_en  = 1'b1;
        bs = obs_col.size();
        bf = n_fin;
        bd = n_done;
        bh = n_hit;
        start_scan(8'hA5, 8'd1, 6'd1, 2);
        wait_done(bd);
        inj_en = 1'b0;
        chk("abort_starts", 32'(obs_col.size() - bs), 32'(2));
        chk("abort_hit_seen", 32'(n_hit - bh), 32'(1));
        chk("abort_finished", 32'(n_fin - bf), 32'(1));
        chk("abort_flag", 32'(aborted), 32'(1));
        chk("abort_col_hold", 32'(col), 32'(2));
        chk("abort_pass_hold", 32'(pass_count), 32'(0));

        // Asynchronous reset while the drivers are absorbing an update.
        max_dly = 3;
        start_scan(8'h0F, 8'd2, 6'd1, 3);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clock);
            if (update_req) found = 1'b1;
        end
        chk("reach_update", 32'(found), 32'(1));
        #1 reset_n = 1'b0;
        #1;
        chk("async_col_en", 32'(col_en), 32'(0));
        chk("async_busy", 32'(busy), 32'(0));
        chk("async_update_req", 32'(update_req), 32'(0));
        @(negedge clock);
        reset_n = 1'b1;
        run_scan(8'h3C, 8'd1, 6'd2, 2);

        for (int r = 0; r < 12; r++) begin
            logic [7:0] m;
            logic [7:0] p;
            logic [5:0] d;
            m = 8'($urandom_range(1, 255));
            p = 8'($urandom_range(1, 3));
            d = 6'($urandom_range(0, 6));
            run_scan(m, p, d, $urandom_range(0, 4));
        end

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
